// File: rtl/err_vec_gen_if.sv
// Bus bundle for err_vec_gen: E basis memory read port, random coefficient
// handshake, and the packed e-row write port.
interface err_vec_gen_if #(
  parameter int N = 189,
  parameter int M = 8,
  parameter int D = 5,
  parameter int R = 5
);
  localparam int WIDTH = M * D;
  localparam int DEPTH = N / D + ((N % D != 0) ? 1 : 0);
  localparam int EAW   = (R > 1) ? $clog2(R) : 1;
  localparam int RAW   = $clog2(2 * DEPTH);

  logic [M-1:0]     E_din;
  logic [EAW-1:0]   E_addr;
  logic             E_rw;
  logic [R-1:0]     rand_din;
  logic             rand_valid;
  logic             rand_req;
  logic [WIDTH-1:0] e_dout;
  logic [RAW-1:0]   e_addr;
  logic             e_rw;

  modport master (
    input  E_din, rand_din, rand_valid,
    output E_addr, E_rw, rand_req, e_dout, e_addr, e_rw
  );

  modport slave (
    output E_din, rand_din, rand_valid,
    input  E_addr, E_rw, rand_req, e_dout, e_addr, e_rw
  );
endinterface

// File: rtl/err_vec_gen.sv
// Error-vector generator: loads r basis elements of support E, then turns each
// r-bit coefficient word into a GF(2) combination of the basis and writes e1/e2
// d elements per row. Define ERR_NONZERO_EN to discard all-zero coefficient words.
module err_vec_gen #(
  parameter int N        = 189,
  parameter int M        = 8,
  parameter int D        = 5,
  parameter int R        = 5,
  parameter int DELAY_RD = 2
)(
  input  logic clk,
  input  logic rst_b,
  input  logic start,
  output logic finish,
  err_vec_gen_if.master bus
);
  localparam int WIDTH = M * D;
  localparam int DEPTH = N / D + ((N % D != 0) ? 1 : 0);
  localparam int EAW   = (R > 1) ? $clog2(R) : 1;
  localparam int RAW   = $clog2(2 * DEPTH);
  localparam int CW    = $clog2(R + DELAY_RD + 1);
  localparam int KW    = (N > 1) ? $clog2(N) : 1;
  localparam int SW    = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, GEN, FLUSH, DONE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [R-1:0][M-1:0]  b_q, b_d;
  logic [WIDTH-1:0]     pack_q, pack_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 vec_q, vec_d;
  logic [RAW-1:0]       row_q, row_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic [RAW-1:0]       waddr_q, waddr_d;
  logic                 wr_q, wr_d;
  logic [M-1:0]         elem;
  logic [WIDTH-1:0]     row_w;
  logic                 take;

  always_comb begin
    elem = '0;
    for (int j = 0; j < R; j++)
      if (bus.rand_din[j]) elem = elem ^ b_q[j];
  end

`ifdef ERR_NONZERO_EN
  // Zero words still complete the handshake but leave every counter untouched.
  assign take = (state_q == GEN) && bus.rand_valid && (|bus.rand_din);
`else
  assign take = (state_q == GEN) && bus.rand_valid;
`endif

  always_comb begin
    row_w = pack_q;
    for (int s = 0; s < D; s++)
      if (slot_q == SW'(s)) row_w[s*M +: M] = elem;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    pack_d  = pack_q;
    slot_d  = slot_q;
    k_d     = k_q;
    vec_d   = vec_q;
    row_d   = row_q;
    dout_d  = dout_q;
    waddr_d = waddr_q;
    wr_d    = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        cnt_d   = '0;
        pack_d  = '0;
        slot_d  = '0;
        k_d     = '0;
        vec_d   = 1'b0;
        row_d   = '0;
      end
      LOAD: begin
        // cnt_q doubles as read address and, DELAY_RD later, capture index.
        for (int j = 0; j < R; j++)
          if (cnt_q == CW'(j + DELAY_RD)) b_d[j] = bus.E_din;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(R - 1 + DELAY_RD)) begin
          state_d = GEN;
          cnt_d   = '0;
        end
      end
      GEN: if (take) begin
        if (slot_q == SW'(D - 1) || k_q == KW'(N - 1)) begin
          dout_d  = row_w;
          waddr_d = row_q;
          wr_d    = 1'b1;
          pack_d  = '0;
          slot_d  = '0;
          row_d   = row_q + RAW'(1);
        end else begin
          pack_d = row_w;
          slot_d = slot_q + SW'(1);
        end
        if (k_q == KW'(N - 1)) begin
          k_d   = '0;
          vec_d = 1'b1;
          if (vec_q) state_d = FLUSH;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      b_q     <= '0;
      pack_q  <= '0;
      slot_q  <= '0;
      k_q     <= '0;
      vec_q   <= 1'b0;
      row_q   <= '0;
      dout_q  <= '0;
      waddr_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      pack_q  <= pack_d;
      slot_q  <= slot_d;
      k_q     <= k_d;
      vec_q   <= vec_d;
      row_q   <= row_d;
      dout_q  <= dout_d;
      waddr_q <= waddr_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.E_addr   = (state_q == LOAD && cnt_q < CW'(R)) ? cnt_q[EAW-1:0] : '0;
  assign bus.E_rw     = 1'b0;
  assign bus.rand_req = (state_q == GEN);
  assign bus.e_dout   = dout_q;
  assign bus.e_addr   = waddr_q;
  assign bus.e_rw     = wr_q;
  assign finish       = (state_q == DONE);
endmodule

// File: tb/tb_err_vec_gen.sv
// Randomized scoreboard bench for err_vec_gen: a vector-level reference model
// predicts every row write plus the finish/last-write cycles.
module tb_err_vec_gen;
  localparam int N = 189, M = 8, D = 5, R = 5, DLY = 2;
  localparam int WIDTH = M * D;
  localparam int DEPTH = (N + D - 1) / D;
  localparam int GS    = R + DLY + 1;
`ifdef ERR_NONZERO_EN
  localparam bit NZ = 1'b1;
`else
  localparam bit NZ = 1'b0;
`endif

  typedef struct { int addr; logic [WIDTH-1:0] data; } wr_t;

  logic clk = 1'b0, rst_b = 1'b0, start = 1'b0, finish;
  always #5 clk = ~clk;

  err_vec_gen_if #(.N(N), .M(M), .D(D), .R(R)) bus();
  err_vec_gen #(.N(N), .M(M), .D(D), .R(R), .DELAY_RD(DLY)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .finish(finish), .bus(bus)
  );

  // E memory with two cycles of read latency
  logic [M-1:0] basis [R];
  int ap1 = 0, ap2 = 0;
  always @(posedge clk) begin
    ap1 <= int'(bus.E_addr);
    ap2 <= ap1;
  end
  assign bus.E_din = (ap2 < R) ? basis[ap2] : '0;

  int cyc = 0, t0 = 0, mk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  wr_t sb[$];
  logic [WIDTH-1:0] mem [2*DEPTH];
  bit mon_on = 0, chk_req = 0;
  int n_wr, n_fin, fin_k, last_wr, exp_clast;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (mon_on) begin
    wr_t w;
    mk = cyc - t0;
    if (bus.e_rw) begin
      n_wr++;
      last_wr = mk;
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got row %0d expected none", bus.e_addr);
      end else begin
        w = sb.pop_front();
        chk("row_addr", 64'(bus.e_addr), 64'(w.addr));
        chk("row_data", 64'(bus.e_dout), 64'(w.data));
        if (w.addr < 2*DEPTH) mem[w.addr] = bus.e_dout;
      end
    end
    if (finish) begin n_fin++; fin_k = mk; end
    if (mk >= 1 && mk <= R) chk("E_addr", 64'(bus.E_addr), 64'(mk - 1));
    if (chk_req) chk("rand_req", 64'(bus.rand_req), 64'(mk >= GS && mk <= exp_clast));
  end

  function automatic bit vpat(input int vm, input int k);
    if (vm == 0 || k < GS) return 1'b1;
    return ((k - GS) % 2) == 0;
  endfunction

  function automatic logic [R-1:0] word_gen(input int wm, input int i);
    case (wm)
      0:       return R'(i % 32);
      1:       return R'(3);
      default: return (i % 3 == 2) ? '0 : R'($urandom);
    endcase
  endfunction

  // GF(2) span: sum of the basis elements selected by the word
  function automatic logic [M-1:0] span(input logic [R-1:0] w);
    logic [M-1:0] e = '0;
    for (int j = 0; j < R; j++) if (w[j]) e ^= basis[j];
    return e;
  endfunction

  task automatic idle_chk(input string nm);
    chk({nm, "_finish"}, 64'(finish), 0);
    chk({nm, "_e_rw"}, 64'(bus.e_rw), 0);
    chk({nm, "_rand_req"}, 64'(bus.rand_req), 0);
    chk({nm, "_E_addr"}, 64'(bus.E_addr), 0);
    chk({nm, "_E_rw"}, 64'(bus.E_rw), 0);
    chk({nm, "_e_addr"}, 64'(bus.e_addr), 0);
    chk({nm, "_e_dout"}, 64'(bus.e_dout), 0);
  endtask

  task automatic run(input int vm, input int wm, input bit extra_start, input int abort_at);
    logic [R-1:0] words[$];
    logic [M-1:0] coords[$];
    logic [R-1:0] w;
    logic [WIDTH-1:0] row;
    int idx, nc, i, k, cnt;
    nc = 0; i = 0;
    while (nc < 2*N) begin
      w = word_gen(wm, i);
      words.push_back(w);
      if (!NZ || w != 0) begin coords.push_back(span(w)); nc++; end
      i++;
    end
    sb.delete();
    for (int v = 0; v < 2; v++)
      for (int rr = 0; rr < DEPTH; rr++) begin
        row = '0;
        for (int s = 0; s < D; s++)
          if (rr*D + s < N) row[s*M +: M] = coords[v*N + rr*D + s];
        sb.push_back('{v*DEPTH + rr, row});
      end
    k = GS; cnt = 0;
    forever begin
      if (vpat(vm, k)) begin cnt++; if (cnt == words.size()) break; end
      k++;
    end
    exp_clast = k;
    n_wr = 0; n_fin = 0; fin_k = -1; last_wr = -1;
    chk_req = (abort_at < 0);
    idx = 0;
    @(posedge clk); #1;
    t0 = cyc;
    mon_on = 1;
    for (k = 0; k < exp_clast + 20; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      start = (k == 0) || (extra_start && (k == 3 || k == GS + 10));
      bus.rand_valid = vpat(vm, k) && (idx < words.size());
      bus.rand_din   = (idx < words.size()) ? words[idx] : '0;
      @(negedge clk);
      if (bus.rand_req && bus.rand_valid) idx++;
      if (finish) break;
      if (abort_at >= 0 && idx >= abort_at) begin
        @(posedge clk); #1; rst_b = 1'b0;
        @(negedge clk);
        @(posedge clk); #1; rst_b = 1'b1; mon_on = 0; bus.rand_valid = 1'b0;
        @(negedge clk);
        idle_chk("post_reset");
        repeat (4) begin
          @(negedge clk);
          chk("no_write_after_reset", 64'(bus.e_rw), 0);
        end
        sb.delete();
        return;
      end
    end
    start = 1'b0;
    bus.rand_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    mon_on = 0;
    chk("finish_cycle", 64'(fin_k), 64'(exp_clast + 2));
    chk("last_write_cycle", 64'(last_wr), 64'(exp_clast + 1));
    chk("finish_count", 64'(n_fin), 1);
    chk("write_count", 64'(n_wr), 64'(2*DEPTH));
    chk("sb_drained", 64'(sb.size()), 0);
  endtask

  initial begin
    bus.rand_valid = 1'b0;
    bus.rand_din   = '0;
    for (int j = 0; j < R; j++) basis[j] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_chk("reset");
    @(posedge clk); #1;
    rst_b = 1'b1;

    // unit basis, word = global index mod 32
    for (int j = 0; j < R; j++) basis[j] = M'(1 << j);
    run(0, 0, 0, -1);
`ifndef ERR_NONZERO_EN
    chk("tp_row0", 64'(mem[0]), 64'h0403020100);
    chk("tp_row37", 64'(mem[37]), 64'h001C1B1A19);
    chk("tp_row38", 64'(mem[38]), 64'h01001F1E1D);
`endif

    // XOR, not integer add: 0x3 ^ 0x5 = 0x6
    for (int j = 0; j < R; j++) basis[j] = M'($urandom);
    basis[0] = 8'h03;
    basis[1] = 8'h05;
    run(0, 1, 0, -1);
    chk("xor_row0", 64'(mem[0]), 64'h0606060606);
    chk("xor_row37", 64'(mem[37]), 64'h0006060606);

    // toggling rand_valid with random words, every third one zero
    for (int j = 0; j < R; j++) basis[j] = M'($urandom);
    run(1, 2, 0, -1);

    // reset after 50 consumptions, then a clean full run
    run(0, 2, 0, 50);
    for (int j = 0; j < R; j++) basis[j] = M'($urandom);
    run(0, 2, 0, -1);

    // stray start pulses during LOAD and GEN
    run(0, 2, 1, -1);
    for (int j = 0; j < R; j++) basis[j] = M'($urandom);
    run(1, 2, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
